// File: rtl/frame_pattern_tx.sv
// frame_pattern_tx: serial framer emitting sync preamble 1,0,1,1, an MSB-first payload and an idle gap.
// Define FRAME_PATTERN_TX_STUFF_EN to insert a 0 before any payload bit that follows a 1,0,1 history.
module frame_pattern_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

    state_t            state, state_nx;
    logic [1:0]        pre_cnt, pre_cnt_nx;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic [GW-1:0]     gap_cnt, gap_cnt_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              in_ready_nx, tx_bit_nx, tx_en_nx, busy_nx, frame_done_nx;
    logic              load_data, stuff;

`ifdef FRAME_PATTERN_TX_STUFF_EN
    // Last three bits put on the wire; the preamble always leaves 0,1,1 here.
    logic [2:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist <= '0;
        else if (tx_en_nx)
            hist <= {hist[1:0], tx_bit_nx};
    end

    always_comb stuff = (hist == 3'b101);
`else
    always_comb stuff = 1'b0;
`endif

    // All outputs are registered, so the next-state logic also produces the next cycle's outputs.
    always_comb begin
        state_nx      = state;
        pre_cnt_nx    = pre_cnt;
        bit_cnt_nx    = bit_cnt;
        gap_cnt_nx    = gap_cnt;
        shreg_nx      = shreg;
        in_ready_nx   = 1'b0;
        tx_bit_nx     = 1'b0;
        tx_en_nx      = 1'b0;
        busy_nx       = 1'b1;
        frame_done_nx = 1'b0;
        load_data     = 1'b0;

        unique case (state)
            IDLE: begin
                busy_nx     = 1'b0;
                in_ready_nx = 1'b1;
                if (in_valid && in_ready) begin
                    state_nx    = PRE;
                    pre_cnt_nx  = '0;
                    bit_cnt_nx  = '0;
                    shreg_nx    = in_data;
                    tx_bit_nx   = 1'b1;
                    tx_en_nx    = 1'b1;
                    busy_nx     = 1'b1;
                    in_ready_nx = 1'b0;
                end
            end
            PRE: begin
                if (pre_cnt == 2'd3) begin
                    load_data = 1'b1;
                end else begin
                    pre_cnt_nx = pre_cnt + 2'd1;
                    tx_en_nx   = 1'b1;
                    tx_bit_nx  = (pre_cnt != 2'd0);
                end
            end
            DATA: begin
                if (bit_cnt != CNT_LAST) begin
                    load_data = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    state_nx    = IDLE;
                    busy_nx     = 1'b0;
                    in_ready_nx = 1'b1;
                end else begin
                    state_nx   = GAP;
                    gap_cnt_nx = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx    = IDLE;
                    busy_nx     = 1'b0;
                    in_ready_nx = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A stuffed slot emits 0 and leaves the payload and bit counter untouched.
        if (load_data) begin
            state_nx = DATA;
            tx_en_nx = 1'b1;
            if (!stuff) begin
                tx_bit_nx     = shreg[DATA_W-1];
                shreg_nx      = shreg << 1;
                bit_cnt_nx    = bit_cnt + 1'b1;
                frame_done_nx = (bit_cnt == CNT_LAST - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            in_ready   <= 1'b0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            pre_cnt    <= pre_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            gap_cnt    <= gap_cnt_nx;
            shreg      <= shreg_nx;
            in_ready   <= in_ready_nx;
            tx_bit     <= tx_bit_nx;
            tx_en      <= tx_en_nx;
            busy       <= busy_nx;
            frame_done <= frame_done_nx;
        end
    end
endmodule

// File: tb/tb_frame_pattern_tx.sv
// Self-checking bench for frame_pattern_tx: randomized words compared against a frame-level model.
module tb_frame_pattern_tx;
    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 2;
    localparam int MAXC       = 64;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready, tx_bit, tx_en, busy, frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Index k holds cycle E+k, where E is the accepting edge.
    bit obs_bit[MAXC], obs_en[MAXC], obs_done[MAXC], obs_busy[MAXC], obs_rdy[MAXC];
    bit exp_bit[MAXC], exp_en[MAXC], exp_done[MAXC], exp_busy[MAXC], exp_rdy[MAXC];
    int exp_len;

    frame_pattern_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_bit     (tx_bit),
        .tx_en      (tx_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wire sequence: preamble, then payload MSB first, with a 0 inserted after any 1,0,1 when stuffing.
    function automatic void build_expect(input logic [DATA_W-1:0] w);
        bit wq[$];
        wq = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = DATA_W - 1; i >= 0; i--) begin
`ifdef FRAME_PATTERN_TX_STUFF_EN
            if (wq[$-2] == 1'b1 && wq[$-1] == 1'b0 && wq[$] == 1'b1)
                wq.push_back(1'b0);
`endif
            wq.push_back(w[i]);
        end
        for (int k = 0; k < MAXC; k++) begin
            exp_bit[k] = 0; exp_en[k] = 0; exp_done[k] = 0; exp_busy[k] = 0; exp_rdy[k] = 0;
        end
        for (int k = 1; k <= wq.size(); k++) begin
            exp_en[k]  = 1'b1;
            exp_bit[k] = wq[k-1];
        end
        exp_done[wq.size()] = 1'b1;
        for (int k = 1; k <= wq.size() + GAP_CYCLES; k++) exp_busy[k] = 1'b1;
        exp_len          = wq.size() + GAP_CYCLES + 1;
        exp_rdy[exp_len] = 1'b1;
    endfunction

    function automatic logic [4:0] obs_vec(input int k);
        return {obs_en[k], obs_bit[k], obs_done[k], obs_busy[k], obs_rdy[k]};
    endfunction

    function automatic logic [4:0] exp_vec(input int k);
        return {exp_en[k], exp_bit[k], exp_done[k], exp_busy[k], exp_rdy[k]};
    endfunction

    // Called at a negedge with in_valid already raised; records cycles E+1..E+n.
    task automatic capture(input int n, input bit hold, input bit scramble,
                           input logic [DATA_W-1:0] final_data);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            obs_bit[k] = tx_bit; obs_en[k] = tx_en; obs_done[k] = frame_done;
            obs_busy[k] = busy; obs_rdy[k] = in_ready;
            if (k == 1 && !hold) in_valid = 1'b0;
            if (scramble) in_data = (k >= n - 1) ? final_data : DATA_W'($urandom);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_ready_timeout: in_ready=%b required=1", name, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, tx_en, busy, frame_done, tx_bit} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_values: rdy,en,busy,done,bit=%b required=00000",
                     {in_ready, tx_en, busy, frame_done, tx_bit});
        end
        #2 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, tx_en, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_release: rdy,en,busy=%b required=100", {in_ready, tx_en, busy});
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({tx_en, tx_bit, busy} !== 3'b111) begin
            n_errors++;
            $display("FAIL reset_first_frame: en,bit,busy=%b required=111", {tx_en, tx_bit, busy});
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, tx_en, busy, frame_done, tx_bit} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_async: rdy,en,busy,done,bit=%b required=00000",
                     {in_ready, tx_en, busy, frame_done, tx_bit});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        wait_ready("basic");
        in_valid = 1'b1; in_data = 8'hA5;
        build_expect(8'hA5);
        capture(exp_len, 1'b0, 1'b0, '0);
        for (int k = 1; k <= exp_len; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL basic_E+%0d en,bit,done,busy,rdy=%b required=%b", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_back_to_back;
        wait_ready("b2b");
        in_valid = 1'b1; in_data = 8'hFF;
        build_expect(8'hFF);
        capture(exp_len, 1'b1, 1'b1, 8'h00);
        for (int k = 1; k <= exp_len; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL b2b_first_E+%0d en,bit,done,busy,rdy=%b required=%b", k, obs_vec(k), exp_vec(k));
            end
        end
        build_expect(8'h00);
        capture(exp_len, 1'b0, 1'b0, '0);
        for (int k = 1; k <= exp_len; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL b2b_second_E+%0d en,bit,done,busy,rdy=%b required=%b", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_abort;
        int done_seen = 0;
        wait_ready("abort");
        in_valid = 1'b1; in_data = 8'hA5;
        build_expect(8'hA5);
        capture(7, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 7; k++) if (obs_done[k]) done_seen++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_en, busy, frame_done, in_ready, tx_bit} !== 5'b0) begin
            n_errors++;
            $display("FAIL abort_async: en,busy,done,rdy,bit=%b required=00000",
                     {tx_en, busy, frame_done, in_ready, tx_bit});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_errors++;
            $display("FAIL abort_no_done: frame_done pulses=%0d required=0", done_seen);
        end
        wait_ready("abort_next");
        in_valid = 1'b1; in_data = 8'h3C;
        build_expect(8'h3C);
        capture(exp_len, 1'b0, 1'b0, '0);
        for (int k = 1; k <= exp_len; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL abort_next_E+%0d en,bit,done,busy,rdy=%b required=%b", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_random;
        logic [DATA_W-1:0] w;
        for (int it = 0; it < 20; it++) begin
            wait_ready("random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = DATA_W'($urandom);
            in_valid = 1'b1; in_data = w;
            build_expect(w);
            capture(exp_len, 1'b0, 1'b1, DATA_W'($urandom));
            for (int k = 1; k <= exp_len; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_errors++;
                    $display("FAIL random_%0d_word_%h_E+%0d en,bit,done,busy,rdy=%b required=%b",
                             it, w, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

`ifdef FRAME_PATTERN_TX_STUFF_EN
    task automatic test_stuff;
        logic [DATA_W-1:0] words[3] = '{8'hB0, 8'hFF, 8'h00};
        int                lens[3]  = '{14, 12, 12};
        bit                b0_wire[14] = '{1,0,1,1, 1,0,1,0,1,0,0,0,0,0};
        for (int t = 0; t < 3; t++) begin
            int n_en = 0, n_hits = 0, hit_at = -1;
            bit wb[$];
            wait_ready("stuff");
            in_valid = 1'b1; in_data = words[t];
            build_expect(words[t]);
            capture(exp_len, 1'b0, 1'b0, '0);
            for (int k = 1; k <= exp_len; k++) begin
                if (obs_en[k]) begin
                    n_en++;
                    wb.push_back(obs_bit[k]);
                end
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_errors++;
                    $display("FAIL stuff_%h_E+%0d en,bit,done,busy,rdy=%b required=%b",
                             words[t], k, obs_vec(k), exp_vec(k));
                end
            end
            n_checks++;
            if (n_en != lens[t]) begin
                n_errors++;
                $display("FAIL stuff_%h_len: tx_en cycles=%0d required=%0d", words[t], n_en, lens[t]);
            end
            for (int j = 3; j < wb.size(); j++)
                if (wb[j-3] && !wb[j-2] && wb[j-1] && wb[j]) begin
                    n_hits++;
                    if (hit_at < 0) hit_at = j;
                end
            n_checks++;
            if (n_hits != 1 || hit_at != 3) begin
                n_errors++;
                $display("FAIL stuff_%h_detector: 1011 hits=%0d first_at=%0d required=1 at 3",
                         words[t], n_hits, hit_at);
            end
            if (t == 0) begin
                for (int j = 0; j < 14; j++) begin
                    n_checks++;
                    if (j >= wb.size() || wb[j] !== b0_wire[j]) begin
                        n_errors++;
                        $display("FAIL stuff_b0_wire_%0d: bit=%b required=%b", j,
                                 (j < wb.size()) ? wb[j] : 1'bx, b0_wire[j]);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef FRAME_PATTERN_TX_STUFF_EN
        test_stuff();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/frame_pattern_tx.md
# frame_pattern_tx

Serial frame transmitter that feeds the single-bit `x` input of the team's "1011" Mealy sequence detector. It accepts a parallel word over a valid/ready handshake and emits the 4-bit sync preamble 1,0,1,1 followed by the word, MSB first, one bit per clock. An enforced idle gap follows each frame so that the detector's FSM returns to its start state between frames. An optional bit-stuffing mode guarantees that the sync pattern never appears inside the payload.

## Interface
- `DATA_W`, default 8: payload width in bits; must be ≥ 1.
- `GAP_CYCLES`, default 2: number of idle cycles forced after each frame; must be ≥ 0.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  DATA_W  payload word; sampled only on the accepting edge.
- `in_ready`  out  1  block can accept a word; registered.
- `tx_bit`  out  1  serial bit to the detector `x`; registered.
- `tx_en`  out  1  `tx_bit` is part of a frame (preamble, payload or stuffed bit); registered.
- `busy`  out  1  high from the accepting edge until the return to IDLE.
- `frame_done`  out  1  one-cycle pulse, high during the cycle that carries the last payload bit.

## Operation
- States and transitions:
  - IDLE → PRE on `in_valid && in_ready`.
  - PRE lasts 4 cycles, then → DATA.
  - DATA → GAP after the last payload bit, or directly → IDLE when `GAP_CYCLES = 0`.
  - GAP lasts `GAP_CYCLES` cycles, then → IDLE.
- Accept:
  - `in_data` is copied into a DATA_W shift register on the accepting edge.
  - `in_data` and `in_valid` are ignored whenever `in_ready` = 0.
- PRE: `tx_bit` = 1, 0, 1, 1 on consecutive cycles; `tx_en` = 1.
- DATA:
  - `tx_bit` = shift-register MSB; shift left one bit per emitted payload bit; `tx_en` = 1.
  - A bit counter of width $clog2(DATA_W+1) counts payload bits only.
- GAP and IDLE: `tx_bit` = 0, `tx_en` = 0.
- `in_ready` = 1 only in IDLE. It is registered, so it rises in the first IDLE cycle.
- `busy` = 1 in PRE, DATA and GAP.
- A mid-frame `rst` aborts the frame immediately:
  - the word is discarded;
  - no `frame_done` is generated;
  - the next frame starts with a full preamble.
- Reset values:
  - `tx_bit` = 0, `tx_en` = 0, `busy` = 0, `frame_done` = 0, `in_ready` = 0;
  - state = IDLE, all counters and the shift register = 0.
- `in_ready` rises on the first clock edge after `rst` deasserts.

## Timing
- Word accepted at edge E. Numbering cycles from E:
  - `tx_en` rises in cycle E+1;
  - preamble occupies E+1..E+4;
  - payload occupies E+5..E+4+DATA_W, with no stuffing;
  - `frame_done` is high in cycle E+4+DATA_W.
- After the frame, GAP occupies the next `GAP_CYCLES` cycles; `in_ready` = 1 in the cycle after that.
- Minimum `tx_en`-low time between frames is `GAP_CYCLES + 1`, including the accept cycle.
- Back-to-back: with `in_valid` held high, the next word is accepted in the first IDLE cycle.
- Frame length without stuffing is `4 + DATA_W` cycles with `tx_en` = 1.

## Configuration
- `FRAME_PATTERN_TX_STUFF_EN` defined:
  - The block tracks the last 3 emitted frame bits; the history after the preamble is 0,1,1.
  - Before each payload bit, if the history is 1,0,1, the block emits one stuffed 0 (`tx_en` = 1). The stuffed bit does not consume payload or advance the bit counter.
  - No stuffed bit is emitted after the final payload bit.
  - `frame_done` is still aligned to the last payload bit; the frame is extended by the number of stuffed bits.
- `FRAME_PATTERN_TX_STUFF_EN` undefined: no history logic; payload is sent verbatim with fixed frame length.

## Test plan
- Reset:
  - assert `rst` mid-clock → all outputs take their reset values immediately;
  - deassert → `in_ready` = 1 after the first edge;
  - `in_valid` held high while `rst` = 1 → no frame starts.
- Basic frame, `DATA_W` = 8, `GAP_CYCLES` = 2, no stuffing, `in_data` = 0xA5 accepted at E:
  - `tx_bit` over E+1..E+12 = 1,0,1,1,1,0,1,0,0,1,0,1;
  - `frame_done` only in E+12;
  - `tx_en` = 0 in E+13..E+14;
  - `in_ready` = 1 in E+15.
- Back-to-back: `in_valid` held high with 0xFF then 0x00 → second accept occurs in E+15; second preamble in E+16..E+19; `in_data` changes while `in_ready` = 0 are ignored.
- Abort: `rst` pulsed in the 3rd payload cycle of 0xA5 → `tx_en` = 0 immediately; the next frame (0x3C) emits a full preamble then 0,0,1,1,1,1,0,0; no `frame_done` for the aborted word.
- Stuffing on, 0xB0:
  - payload wire sequence = 1,0,1,0*,1,0*,0,0,0,0 (* = stuffed bit);
  - 14 `tx_en` cycles;
  - `frame_done` on the final 0;
  - a connected 1011 detector asserts `z` only on the preamble's last bit.
- Stuffing on, 0xFF and 0x00 → no stuffed bits; frame length is 12 cycles.
